// File: rtl/decode_pkg.sv
// Shared opcode, funct and instruction-class definitions for the decode queue.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [1:0] {
        CLASS_R = 2'd0,
        CLASS_I = 2'd1,
        CLASS_J = 2'd2
    } iclass_e;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// DEPTH-entry circular buffer holding {instr, pc} words, with synchronous flush.
module decode_fifo
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/decode_queue.sv
// Instruction queue with combinational decode of the head entry.
// Optional DECODE_PERF_EN adds saturating pop and stall counters.
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32,
`ifdef DECODE_PERF_EN
    parameter int unsigned CNT_W = 16,
`endif
    parameter int unsigned IMM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DECODE_PERF_EN
    output logic [CNT_W-1:0] perf_decoded,
    output logic [CNT_W-1:0] perf_stall,
`endif
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm_ext,
    output logic [PC_W-1:0]  jump_target,
    output logic [PC_W-1:0]  pc_out,
    output logic [1:0]       iclass,
    output logic [4:0]       dest_reg,
    output logic             reg_write,
    output logic             illegal
);

    localparam int unsigned EXT_W = (IMM_W > 32) ? IMM_W : 32;

    logic            push, pop, full, empty;
    logic [31:0]     instr_h;
    logic [PC_W-1:0] pc_h, pc_plus4;
    logic [EXT_W-1:0] sext_w, zext_w, lui_w;
    iclass_e         cls;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    decode_fifo #(
        .DEPTH (DEPTH),
        .W     (32 + PC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_instr, in_pc}),
        .rdata_o ({instr_h, pc_h}),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pc_plus4 = pc_h + PC_W'(4);
    assign sext_w   = EXT_W'($signed(instr_h[15:0]));
    assign zext_w   = EXT_W'(instr_h[15:0]);
    assign lui_w    = EXT_W'({instr_h[15:0], 16'h0000});

    // Every decoded output is forced to zero while the head is empty.
    always_comb begin
        opcode      = '0;
        rs          = '0;
        rt          = '0;
        rd          = '0;
        shamt       = '0;
        funct       = '0;
        imm_ext     = '0;
        jump_target = '0;
        pc_out      = '0;
        iclass      = '0;
        dest_reg    = '0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        cls         = CLASS_I;
        if (out_valid) begin
            opcode = instr_h[31:26];
            rs     = instr_h[25:21];
            rt     = instr_h[20:16];
            rd     = instr_h[15:11];
            shamt  = instr_h[10:6];
            funct  = instr_h[5:0];
            pc_out = pc_h;

            case (opcode)
                OP_RTYPE:      cls = CLASS_R;
                OP_J, OP_JAL:  cls = CLASS_J;
                default:       cls = CLASS_I;
            endcase
            iclass = cls;

            case (opcode)
                OP_ANDI, OP_ORI, OP_XORI: imm_ext = IMM_W'(zext_w);
                OP_LUI:                   imm_ext = IMM_W'(lui_w);
                default:                  imm_ext = IMM_W'(sext_w);
            endcase

            jump_target       = pc_plus4;
            jump_target[27:0] = {instr_h[25:0], 2'b00};

            case (opcode)
                OP_RTYPE: dest_reg = rd;
                OP_JAL:   dest_reg = 5'd31;
                OP_J:     dest_reg = 5'd0;
                default:  dest_reg = rt;
            endcase

            illegal = ~is_legal(opcode);
            case (opcode)
                OP_RTYPE:                             reg_write = (funct != FUNCT_JR);
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
                OP_LW, OP_JAL:                        reg_write = 1'b1;
                default:                              reg_write = 1'b0;
            endcase
        end
    end

`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] dec_q, dec_d, stall_q, stall_d;

    always_comb begin
        dec_d   = dec_q;
        stall_d = stall_q;
        if (pop && dec_q != '1) dec_d = dec_q + 1'b1;
        if (out_valid && !out_ready && stall_q != '1) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_q   <= '0;
            stall_q <= '0;
        end else begin
            dec_q   <= dec_d;
            stall_q <= stall_d;
        end
    end

    assign perf_decoded = dec_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue against a queue-based reference model.
module tb_decode_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned IMM_W = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             in_ready, out_valid;
    logic [5:0]       opcode, funct;
    logic [4:0]       rs, rt, rd, shamt, dest_reg;
    logic [IMM_W-1:0] imm_ext;
    logic [PC_W-1:0]  jump_target, pc_out;
    logic [1:0]       iclass;
    logic             reg_write, illegal;
`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] perf_decoded, perf_stall;
`endif

    decode_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
`ifdef DECODE_PERF_EN
        .CNT_W (CNT_W),
`endif
        .IMM_W (IMM_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef DECODE_PERF_EN
        .perf_decoded(perf_decoded),
        .perf_stall  (perf_stall),
`endif
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm_ext     (imm_ext),
        .jump_target (jump_target),
        .pc_out      (pc_out),
        .iclass      (iclass),
        .dest_reg    (dest_reg),
        .reg_write   (reg_write),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] q[$];
    int unsigned m_dec = 0;
    int unsigned m_stall = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ins, pc, e_imm, e_jt;
        logic [5:0]  op;
        logic        e_legal, e_rw;
        logic [1:0]  e_cls;
        logic [4:0]  e_dest;
        ins = '0; pc = '0; op = '0; e_imm = '0; e_jt = '0;
        e_legal = 1'b0; e_rw = 1'b0; e_cls = '0; e_dest = '0;
        if (q.size() != 0) begin
            ins = q[0][63:32];
            pc  = q[0][31:0];
            op  = ins[31:26];
            e_legal = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B};
            e_cls   = (op == 6'h00) ? 2'd0 : (op == 6'h02 || op == 6'h03) ? 2'd2 : 2'd1;
            if (op inside {6'h0C, 6'h0D, 6'h0E}) e_imm = {16'h0, ins[15:0]};
            else if (op == 6'h0F)                e_imm = {ins[15:0], 16'h0};
            else e_imm = ins[15] ? (32'hFFFF0000 | ins[15:0]) : {16'h0, ins[15:0]};
            e_jt = ((pc + 32'd4) & 32'hF0000000) | {4'h0, ins[25:0], 2'b00};
            if (op == 6'h03)      e_dest = 5'd31;
            else if (op == 6'h02) e_dest = 5'd0;
            else if (op == 6'h00) e_dest = ins[15:11];
            else                  e_dest = ins[20:16];
            e_rw = e_legal && ((op == 6'h00 && ins[5:0] != 6'h08) ||
                               (op >= 6'h08 && op <= 6'h0F) || op == 6'h23 || op == 6'h03);
        end
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() != DEPTH);
        chk("opcode", opcode, op);
        chk("rs", rs, ins[25:21]);
        chk("rt", rt, ins[20:16]);
        chk("rd", rd, ins[15:11]);
        chk("shamt", shamt, ins[10:6]);
        chk("funct", funct, ins[5:0]);
        chk("imm_ext", imm_ext, e_imm);
        chk("jump_target", jump_target, e_jt);
        chk("pc_out", pc_out, pc);
        chk("iclass", iclass, e_cls);
        chk("dest_reg", dest_reg, e_dest);
        chk("reg_write", reg_write, e_rw);
        chk("illegal", illegal, (q.size() != 0) && !e_legal);
`ifdef DECODE_PERF_EN
        chk("perf_decoded", perf_decoded, m_dec);
        chk("perf_stall", perf_stall, m_stall);
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic do_push, do_pop;
        in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        do_push = iv && (q.size() != DEPTH) && !fl;
        do_pop  = (q.size() != 0) && ordy && !fl;
        if (q.size() != 0 && !ordy && m_stall != CNT_MAX) m_stall++;
        if (do_pop && m_dec != CNT_MAX) m_dec++;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({ins, pc});
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2 rst = 1'b0;
        q.delete(); m_dec = 0; m_stall = 0;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [5:0] op_tbl [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01, 6'h10};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, ins, pc;
        logic [5:0]  op;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;

        step(1'b1, 32'h014B4820, 32'h100, 1'b0, 1'b0);
        chk("tp_add_iclass", iclass, 0);
        chk("tp_add_rs", rs, 10);
        chk("tp_add_rt", rt, 11);
        chk("tp_add_rd", rd, 9);
        chk("tp_add_dest", dest_reg, 9);
        chk("tp_add_rw", reg_write, 1);
        chk("tp_add_illegal", illegal, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        step(1'b1, 32'h2008FFFF, 32'h200, 1'b0, 1'b0);
        chk("tp_addi_imm", imm_ext, 32'hFFFFFFFF);
        chk("tp_addi_dest", dest_reg, 8);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h3108FFFF, 32'h204, 1'b0, 1'b0);
        chk("tp_andi_imm", imm_ext, 32'h0000FFFF);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h3C081234, 32'h208, 1'b0, 1'b0);
        chk("tp_lui_imm", imm_ext, 32'h12340000);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        step(1'b1, 32'h0C000040, 32'h40000000, 1'b0, 1'b0);
        chk("tp_jal_target", jump_target, 32'h40000100);
        chk("tp_jal_dest", dest_reg, 31);
        chk("tp_jal_rw", reg_write, 1);
        chk("tp_jal_iclass", iclass, 2);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        step(1'b1, 32'h014B4820, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h3C081234, 32'h304, 1'b0, 1'b0);
        chk("tp_full_ready", in_ready, 0);
        step(1'b1, 32'h2008FFFF, 32'h308, 1'b0, 1'b0);
        chk("tp_full_hold_pc", pc_out, 32'h300);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("tp_order_pc", pc_out, 32'h304);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("tp_drain_valid", out_valid, 0);
        chk("tp_drain_ready", in_ready, 1);

        step(1'b1, 32'h11111111, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 32'h404, 1'b0, 1'b0);
        step(1'b1, 32'h014B4820, 32'h408, 1'b0, 1'b1);
        chk("tp_flush_valid", out_valid, 0);
        chk("tp_flush_ready", in_ready, 1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("tp_flush_discard", out_valid, 0);

        step(1'b1, 32'hFC000000, 32'h500, 1'b0, 1'b0);
        chk("tp_illegal", illegal, 1);
        chk("tp_illegal_rw", reg_write, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            r   = $urandom();
            op  = op_tbl[$urandom_range(17)];
            ins = {op, r[25:0]};
            if (op == 6'h00 && $urandom_range(3) == 0) ins[5:0] = 6'h08;
            pc  = ($urandom_range(7) == 0) ? 32'hFFFFFFFC : $urandom();
            step($urandom_range(3) != 0, ins, pc, $urandom_range(9) < 6, $urandom_range(19) == 0);
        end

        step(1'b1, 32'h014B4820, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'h2008FFFF, 32'h604, 1'b0, 1'b0);
        async_reset();
        chk("tp_rst_valid", out_valid, 0);
        chk("tp_rst_rd", rd, 0);

        step(1'b1, 32'h014B4820, 32'h700, 1'b0, 1'b0);
        step(1'b1, 32'h2008FFFF, 32'h704, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h3108FFFF, 32'h708, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
`ifdef DECODE_PERF_EN
        chk("tp_perf_decoded", perf_decoded, 3);
        chk("tp_perf_stall", perf_stall, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register instruction decode stage.
- Buffers fetched 32-bit MIPS-format instructions and their PCs in a DEPTH-entry queue with valid/ready handshakes on both sides.
- Presents the head entry fully decoded: fields, instruction class, extended immediate, jump target, destination register, write-enable and illegal flag.
- Sits between the fetch unit and the register-read/execute stage; supports a pipeline flush.

Parameters:
- DEPTH, 2: queue entries; power of two, ≥2.
- PC_W, 32: PC width; ≥28.
- IMM_W, 32: width of the extended immediate; ≥16.
- CNT_W, 16: perf-counter width (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm_ext  out  IMM_W  extended immediate.
- jump_target  out  PC_W  J-type target.
- pc_out  out  PC_W  PC of head.
- iclass  out  2  0=R, 1=I, 2=J.
- dest_reg  out  5  register written.
- reg_write  out  1  instruction writes a register.
- illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst=0, asynchronous): queue empty, pointers and count 0, in_ready=1, out_valid=0. All decoded outputs are 0 whenever out_valid=0, including during and after reset.
- Push: occurs when in_valid & in_ready & ~flush.
- Pop: occurs when out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It is not combinationally dependent on out_ready; no pass-through when full.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1 (storage is registered; decode is combinational from the head).
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Stall: with out_valid=1 and out_ready=0, the head and all outputs are held stable.
- Flush: pointers and count cleared at the next edge; flush overrides any push or pop in the same cycle; out_valid=0 from the next cycle.
- Decoding:
  - iclass: R if opcode=0x00; J if opcode ∈ {0x02,0x03}; otherwise I.
  - imm_ext: zero-extended instr[15:0] for opcode ∈ {0x0C,0x0D,0x0E}; {instr[15:0],16'b0} (truncated or zero-padded to IMM_W) for 0x0F (lui); sign-extended instr[15:0] otherwise.
  - jump_target = {pc_plus4[PC_W-1:28], instr[25:0], 2'b00}, where pc_plus4 = pc_out+4 modulo 2^PC_W.
  - dest_reg: R → rd; I → rt; 0x03 (jal) → 31; 0x02 → 0.
  - reg_write: R with funct≠0x08; I-type ALU ops/lui/lw (0x08–0x0F, 0x23); jal. It is 0 for beq/bne/sw/j/jr.
  - illegal=1 when opcode ∉ {0x00,0x02,0x03,0x04,0x05,0x08–0x0F,0x23,0x2B}. When illegal=1, reg_write=0 and iclass is still computed.

Optional Feature:
- DECODE_PERF_EN defined:
  - Adds outputs perf_decoded [CNT_W] (count of pops) and perf_stall [CNT_W] (cycles with out_valid & ~out_ready).
  - Both counters saturate at all-ones, are cleared by rst, and are not cleared by flush.
- Undefined: these ports and counters do not exist.

Decomposition:
- decode_pkg:
  - opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI…OP_LUI, OP_LW, OP_SW).
  - FUNCT_JR.
  - iclass codes (CLASS_R/I/J).
  - function is_legal(opcode).
- Sub-module decode_fifo: parametrised DEPTH×(32+PC_W) storage with count, full/empty, and flush.
- decode_queue instantiates decode_fifo and holds the combinational decode.

Test Plan:
- Reset then push 0x014B4820 (add $9,$10,$11), pc=0x100 → next cycle out_valid=1, iclass=0, rs=10, rt=11, rd=9, dest_reg=9, reg_write=1, illegal=0.
- Push 0x2008FFFF (addi $8,$0,-1) → imm_ext=0xFFFFFFFF, dest_reg=8. Push 0x3108FFFF (andi) → imm_ext=0x0000FFFF. Push 0x3C081234 (lui) → imm_ext=0x12340000.
- Push 0x0C000040 (jal), pc=0x40000000 → jump_target=0x40000100, dest_reg=31, reg_write=1, iclass=2.
- out_ready=0, push DEPTH=2 words → in_ready=0 after the second push; a third offer is not accepted; outputs are held. Release out_ready → words are popped in order; in_ready=1.
- Queue full, assert flush together with in_valid=1 → next cycle out_valid=0, count=0, in_ready=1; the offered word is discarded.
- Push opcode 0x3F → illegal=1, reg_write=0. Assert rst mid-stream → outputs 0 immediately. With DECODE_PERF_EN: 3 pops and 4 stall cycles → perf_decoded=3, perf_stall=4.
